// File: rtl/ddr_tx_pkg.sv
// ddr_tx_pkg: shared state encoding and preamble pattern for the DDR transmit framer.
package ddr_tx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    DATA  = 2'd2,
    GUARD = 2'd3
  } state_t;
  localparam logic PRE_D0 = 1'b1;
  localparam logic PRE_D1 = 1'b0;
endpackage

// File: rtl/ddr_pair_shifter.sv
// ddr_pair_shifter: word load/shift register yielding the bit pair of the upcoming beat, LSB pair first.
module ddr_pair_shifter #(
  parameter int DATA_W = 8,
  parameter int BW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic [BW-1:0]     beat,
  output logic [1:0]        pair,
  output logic              last_beat
);
  localparam int N = DATA_W / 2;
  logic [DATA_W-1:0] sr, sr_n;
  always_comb begin
    sr_n      = load ? data : sr >> 2;
    pair      = sr_n[1:0];
    last_beat = beat == BW'(N - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else     sr <= sr_n;
endmodule

// File: rtl/ddr_tx_framer.sv
// ddr_tx_framer: frames valid/ready words as preamble, DDR data beats and guard for an ODDR output.
// Outputs are registered from next-state values so tx_oen never decodes through a transient state.
module ddr_tx_framer
  import ddr_tx_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int PREAMBLE_BEATS = 4,
  parameter int GUARD_BEATS    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              d0,
  output logic              d1,
  output logic              tx_oen,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);
  localparam int N    = DATA_W / 2;
  localparam int BW   = N > 1 ? $clog2(N) : 1;
  localparam int CMAX = PREAMBLE_BEATS > GUARD_BEATS ? PREAMBLE_BEATS : GUARD_BEATS;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] beat, beat_n;
  logic          last_f, last_n;
  logic          hs, pre_end, guard_end, last_beat;
  logic [1:0]    pair;
  ddr_pair_shifter #(.DATA_W(DATA_W), .BW(BW)) u_shift (
    .clk(clk), .rst(rst), .load(hs), .data(s_data), .beat(beat),
    .pair(pair), .last_beat(last_beat)
  );
  always_comb begin
    hs        = s_ready && s_valid;
    pre_end   = state == PRE && cnt == CW'(PREAMBLE_BEATS - 1);
    guard_end = state == GUARD && cnt == CW'(GUARD_BEATS - 1);
    state_n   = state == IDLE ? (s_valid ? PRE : IDLE)
              : state == PRE  ? (pre_end ? (hs ? DATA : GUARD) : PRE)
              : state == DATA ? (last_beat ? (hs ? DATA : GUARD) : DATA)
              : (guard_end ? IDLE : GUARD);
    cnt_n     = (state_n == state && (state == PRE || state == GUARD)) ? cnt + CW'(1) : '0;
    beat_n    = (state == DATA && state_n == DATA && !last_beat) ? beat + BW'(1) : '0;
    last_n    = hs ? s_last : (state == IDLE ? 1'b0 : last_f);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      beat       <= '0;
      last_f     <= 1'b0;
      tx_oen     <= 1'b1;
      d0         <= 1'b0;
      d1         <= 1'b0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      beat       <= beat_n;
      last_f     <= last_n;
      tx_oen     <= state_n == IDLE;
      d0         <= state_n == PRE ? PRE_D0 : state_n == DATA ? pair[0] : 1'b0;
      d1         <= state_n == PRE ? PRE_D1 : state_n == DATA ? pair[1] : 1'b0;
      s_ready    <= (state_n == PRE && cnt_n == CW'(PREAMBLE_BEATS - 1)) ||
                    (state_n == DATA && beat_n == BW'(N - 1) && !last_n);
      busy       <= state_n != IDLE;
      frame_done <= guard_end && last_f;
      underrun   <= state_n == GUARD && state != GUARD && !last_f;
    end
endmodule

// File: tb/tb_ddr_tx_framer.sv
// tb_ddr_tx_framer: directed per-cycle checks of {tx_oen,d0,d1,s_ready,busy,frame_done,underrun}.
module tb_ddr_tx_framer;
  logic       clk = 1'b0, rst = 1'b1;
  logic       s_valid = 1'b0, s_last = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, d0, d1, tx_oen, busy, frame_done, underrun;
  int         n_vec = 0, n_bad = 0;
  localparam logic [6:0] I  = 7'b1000000;
  localparam logic [6:0] IF = 7'b1000010;
  localparam logic [6:0] P  = 7'b0100100;
  localparam logic [6:0] PR = 7'b0101100;
  localparam logic [6:0] G  = 7'b0000100;
  localparam logic [6:0] GU = 7'b0000101;
  ddr_tx_framer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .d0(d0), .d1(d1), .tx_oen(tx_oen), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] dv(input logic a, input logic b, input logic r);
    return {1'b0, a, b, r, 1'b1, 2'b00};
  endfunction
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (oen,d0,d1,rdy,busy,done,ur) at %0t", tag, got, want, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input string tag, input logic [6:0] want);
    chk(tag, {tx_oen, d0, d1, s_ready, busy, frame_done, underrun}, want);
    tick();
  endtask
  task automatic start(input logic [7:0] w, input logic l, input string tag);
    s_valid = 1'b1; s_data = w; s_last = l;
    step({tag, "_idle"}, I);
    step({tag, "_pre0"}, P);
    step({tag, "_pre1"}, P);
    step({tag, "_pre2"}, P);
    step({tag, "_pre3"}, PR);
  endtask
  initial begin
    tick(); tick();
    step("rst_hold", I);
    rst = 1'b0;
    step("post_rst", I);
    start(8'hA5, 1'b1, "a5");
    s_valid = 1'b0;
    step("a5_b0", dv(1, 0, 0));
    step("a5_b1", dv(1, 0, 0));
    step("a5_b2", dv(0, 1, 0));
    step("a5_b3", dv(0, 1, 0));
    step("a5_g0", G);
    step("a5_g1", G);
    step("a5_done", IF);
    step("a5_idle", I);
    start(8'h0F, 1'b0, "b2b");
    s_data = 8'hF0; s_last = 1'b1;
    step("b2b_b0", dv(1, 1, 0));
    step("b2b_b1", dv(1, 1, 0));
    step("b2b_b2", dv(0, 0, 0));
    step("b2b_b3", dv(0, 0, 1));
    s_valid = 1'b0;
    step("b2b_b4", dv(0, 0, 0));
    step("b2b_b5", dv(0, 0, 0));
    step("b2b_b6", dv(1, 1, 0));
    step("b2b_b7", dv(1, 1, 0));
    step("b2b_g0", G);
    step("b2b_g1", G);
    step("b2b_done", IF);
    start(8'h3C, 1'b0, "ur");
    s_valid = 1'b0;
    step("ur_b0", dv(0, 0, 0));
    step("ur_b1", dv(1, 1, 0));
    step("ur_b2", dv(1, 1, 0));
    step("ur_b3", dv(0, 0, 1));
    step("ur_g0", GU);
    step("ur_g1", G);
    step("ur_idle", I);
    step("ur_idle2", I);
    start(8'hA5, 1'b1, "hold");
    step("hold_b0", dv(1, 0, 0));
    step("hold_b1", dv(1, 0, 0));
    step("hold_b2", dv(0, 1, 0));
    step("hold_b3", dv(0, 1, 0));
    step("hold_g0", G);
    step("hold_g1", G);
    step("hold_done", IF);
    step("hold_pre0", P);
    step("hold_pre1", P);
    step("hold_pre2", P);
    step("hold_pre3", PR);
    s_valid = 1'b0;
    step("hold2_b0", dv(1, 0, 0));
    step("hold2_b1", dv(1, 0, 0));
    step("hold2_b2", dv(0, 1, 0));
    step("hold2_b3", dv(0, 1, 0));
    step("hold2_g0", G);
    step("hold2_g1", G);
    step("hold2_done", IF);
    s_valid = 1'b1;
    step("nod_idle", I);
    s_valid = 1'b0;
    step("nod_pre0", P);
    step("nod_pre1", P);
    step("nod_pre2", P);
    step("nod_pre3", PR);
    step("nod_g0", GU);
    step("nod_g1", G);
    step("nod_idle1", I);
    step("nod_idle2", I);
    start(8'hA5, 1'b1, "mid");
    step("mid_b0", dv(1, 0, 0));
    #3 rst = 1'b1;
    #1 chk("mid_rst", {tx_oen, d0, d1, s_ready, busy, frame_done, underrun}, I);
    @(negedge clk);
    rst = 1'b0;
    tick();
    step("mid_pre0", P);
    step("mid_pre1", P);
    step("mid_pre2", P);
    step("mid_pre3", PR);
    s_valid = 1'b0;
    step("mid_b0b", dv(1, 0, 0));
    step("mid_b1", dv(1, 0, 0));
    step("mid_b2", dv(0, 1, 0));
    step("mid_b3", dv(0, 1, 0));
    step("mid_g0", G);
    step("mid_g1", G);
    step("mid_done", IF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
